csa_mult_seq: RTL
=================

CSA_MULT_SEQ -- requirements
Module: csa_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 24, giving the unsigned mantissa operand width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning operands a/b are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH, the multiplicand.
REQ-007 SHALL have port b, input, WIDTH, the multiplier.
REQ-008 SHALL have port out_valid, output, 1, meaning product is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts product.
REQ-010 SHALL have port product, output, 2*WIDTH, the unsigned a*b.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, REDUCE, RESOLVE and DONE, encoded in one state register.
REQ-013 SHALL drive in_ready high only in IDLE; input handshake = in_valid && in_ready on a rising edge.
REQ-014 On the input handshake, SHALL latch a and b, clear sum and carry (2*WIDTH bits each), clear bit counter cnt, and enter REDUCE.
REQ-015 In REDUCE, each edge SHALL compress {sum, carry, pp} through one 2*WIDTH-bit 3:2 carry-save row, where pp = b_reg[cnt] ? (a_reg << cnt) : 0.
REQ-016 The new sum SHALL be the bitwise XOR; the new carry SHALL be the majority vector shifted left by 1 with bit 0 = 0 and the bit shifted out of 2*WIDTH-1 discarded.
REQ-017 cnt SHALL increment each REDUCE edge; on the edge where cnt == WIDTH-1, the state SHALL move to RESOLVE; cnt SHALL never wrap in REDUCE.
REQ-018 In RESOLVE, one edge SHALL register product = sum + carry, truncated to 2*WIDTH bits, enter DONE, and set out_valid.
REQ-019 Latency SHALL be fixed: out_valid rises exactly WIDTH+1 edges after the input-handshake edge (25 for WIDTH=24), independent of operand values; no zero-operand shortcut.
REQ-020 In DONE, out_valid SHALL stay high and product SHALL stay stable until out_ready is sampled high; on that edge out_valid SHALL clear and the state SHALL return to IDLE.
REQ-021 SHALL ignore in_valid, a and b in REDUCE, RESOLVE and DONE; captured operands SHALL not change mid-operation.
REQ-022 Back-to-back operation: the earliest next input handshake SHALL occur on the edge after the output handshake, giving a WIDTH+3-cycle minimum issue interval.
REQ-023 The discarded carry bit in REQ-016 and the truncated bit in REQ-018 SHALL always be 0 for legal unsigned inputs; the bench checks this with an assertion.
REQ-024 product SHALL hold its last value in IDLE, REDUCE and RESOLVE; it is valid only while out_valid is high.

Reset
REQ-025 rst high on a rising edge SHALL force IDLE, cnt=0, sum=0, carry=0, product=0, out_valid=0 and busy=0, with in_ready=1 on the following cycle.
REQ-026 rst SHALL take priority over every handshake; reset during REDUCE, RESOLVE or DONE SHALL abort the operation with no out_valid pulse.
REQ-027 in_valid asserted in the same cycle as rst SHALL not be accepted.

Verification
REQ-028 a=0xFFFFFF, b=0xFFFFFF, out_ready=1 -> out_valid exactly 25 edges after acceptance, product=0xFFFFFE000001.
REQ-029 a=0x800000, b=0x800000 -> product=0x400000000000; a=0x000000, b=0xABCDEF -> product=0, still at latency 25.
REQ-030 a=0xC00000, b=0xA00000, out_ready low for 10 cycles -> product=0x780000000000 held stable, out_valid held high, in_ready low throughout, release on the first out_ready edge.
REQ-031 rst pulsed at REDUCE cnt=12, then a=3, b=5 -> no stale output; the next out_valid carries product=15.
REQ-032 Continuous in_valid with 1000 random operand pairs and random out_ready -> every product equals a*b, the issue interval is >= 27 cycles, and the REQ-023 assertion never fires.

Source files
------------

// File: rtl/csa_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential carry-save multiplier.
// The master side issues operands and consumes products; the slave side is the multiplier.
interface csa_mult_seq_if #(
    parameter int WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/csa_mult_seq.sv
// Sequential unsigned multiplier: one carry-save row per clock folds in one partial
// product, then a single carry-propagate add resolves the redundant sum/carry pair.
module csa_mult_seq #(
    parameter int WIDTH = 24
) (
    input  logic           clk,
    input  logic           rst,
    csa_mult_seq_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REDUCE  = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
    logic [PW-1:0]    product_reg;
    logic [CW-1:0]    cnt;
    logic             out_valid_reg;

    logic [WIDTH-1:0] bit_mask;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    sum_next;
    logic [PW-1:0]    maj_vec;
    logic [PW-1:0]    carry_next;
    logic [PW-1:0]    resolved;

    // One 3:2 compressor row over {sum, carry, pp}; the multiplier bit is picked with a
    // mask so a counter value past the top bit yields an all-zero partial product.
    always_comb begin
        bit_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;
        a_ext      = {{WIDTH{1'b0}}, a_reg};
        pp         = (|(b_reg & bit_mask)) ? (a_ext << cnt) : '0;
        sum_next   = sum ^ carry ^ pp;
        maj_vec    = (sum & carry) | (sum & pp) | (carry & pp);
        carry_next = maj_vec << 1;
        resolved   = sum + carry;
    end

    // Control and datapath state: reset wins over every handshake, operands are frozen
    // once accepted, and the product register only changes when a new result resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum           <= '0;
            carry         <= '0;
            cnt           <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        sum   <= '0;
                        carry <= '0;
                        cnt   <= '0;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    sum   <= sum_next;
                    carry <= carry_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    product_reg   <= resolved;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.product   = product_reg;

endmodule
